// File: rtl/key_count_sched_if.sv
// key_count_sched_if
//   Groups the front-panel signals of key_count_sched: three raw active-low
//   push-buttons in, and the BCD count, step pulse and two seven-segment
//   digits out. The slave modport is the counter block; the master modport is
//   whatever drives the buttons and observes the display.
//   Signals:
//     key_plus, key_minus, key_clear : raw buttons, 0 = pressed, async to clk
//     count[7:0]                     : BCD count, [7:4] tens, [3:0] units
//     step                           : one-cycle pulse when count is updated
//     HEX1[6:0], HEX0[6:0]           : tens/units segments, active-low {g..a}
interface key_count_sched_if;
  logic       key_plus;
  logic       key_minus;
  logic       key_clear;
  logic [7:0] count;
  logic       step;
  logic [6:0] HEX1;
  logic [6:0] HEX0;

  modport master (
    output key_plus, key_minus, key_clear,
    input  count, step, HEX1, HEX0
  );

  modport slave (
    input  key_plus, key_minus, key_clear,
    output count, step, HEX1, HEX0
  );
endinterface

// File: rtl/key_count_sched.sv
// key_count_sched
//   Button controller for a two-digit wrapping BCD counter (00..99).
//   Each raw key is synchronised (2 flops), debounced by its own FSM
//   (REL/IDLE/ARM/HELD[/RPT]) and turned into press (and optionally
//   auto-repeat) events. A registered arbiter applies at most one update per
//   cycle: clear wins and discards plus/minus; plus together with minus is
//   dropped; a lone plus/minus steps the count. HEX digits are registered
//   alongside count.
//   Ports:
//     clk   : system clock, posedge
//     reset : synchronous, active-high
//     bus   : key_count_sched_if.slave (keys in; count, step, HEX1, HEX0 out)
//   Parameters: DEBOUNCE_CYC (>=2), HOLD_CYC (> DEBOUNCE_CYC), REPEAT_CYC (>=2)
//   Build option: define KEY_AUTO_REPEAT_EN to compile in auto-repeat of the
//   plus/minus keys; without it each press yields exactly one event.
module key_count_sched #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000
) (
  input logic             clk,
  input logic             reset,
  key_count_sched_if.slave bus
);

  localparam int unsigned MAX_A = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int unsigned MAX_P = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
  localparam int unsigned CNT_W = $clog2(MAX_P);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    REL,
    IDLE,
    ARM,
    HELD
`ifdef KEY_AUTO_REPEAT_EN
    , RPT
`endif
  } key_state_t;

  // Index 0 = plus, 1 = minus, 2 = clear.
  logic [2:0] w_raw;
  logic [2:0] w_ev;

  assign w_raw = {bus.key_clear, bus.key_minus, bus.key_plus};

  for (genvar g = 0; g < 3; g++) begin : g_key
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit IS_PM = (g != 2);
`endif
    logic             r_s1;
    logic             r_s2;
    key_state_t       r_st;
    key_state_t       w_st_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ev;
    logic             w_ev_nxt;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_st  <= REL;
        r_cnt <= '0;
        r_ev  <= 1'b0;
      end else begin
        r_s1  <= w_raw[g];
        r_s2  <= r_s1;
        r_st  <= w_st_nxt;
        r_cnt <= w_cnt_nxt;
        r_ev  <= w_ev_nxt;
      end
    end

    // The event is registered, so it is visible one edge after the
    // transition decision; the arbiter then adds one more edge.
    always_comb begin
      w_st_nxt  = r_st;
      w_cnt_nxt = r_cnt + 1'b1;
      w_ev_nxt  = 1'b0;
      case (r_st)
        REL: begin
          if (!r_s2) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_st_nxt  = IDLE;
            w_cnt_nxt = '0;
          end
        end
        IDLE: begin
          w_cnt_nxt = '0;
          if (!r_s2) w_st_nxt = ARM;
        end
        ARM: begin
          if (r_s2) begin
            w_st_nxt  = IDLE;
            w_cnt_nxt = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_st_nxt  = HELD;
            w_cnt_nxt = '0;
            w_ev_nxt  = 1'b1;
          end
        end
        HELD: begin
          if (r_s2) begin
            w_st_nxt  = REL;
            w_cnt_nxt = '0;
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (!IS_PM) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_st_nxt  = RPT;
            w_cnt_nxt = '0;
            w_ev_nxt  = 1'b1;
          end
`else
          else begin
            w_cnt_nxt = '0;
          end
`endif
        end
`ifdef KEY_AUTO_REPEAT_EN
        RPT: begin
          if (r_s2) begin
            w_st_nxt  = REL;
            w_cnt_nxt = '0;
          end else if (r_cnt == REP_LAST) begin
            w_cnt_nxt = '0;
            w_ev_nxt  = 1'b1;
          end
        end
`endif
        default: begin
          w_st_nxt  = REL;
          w_cnt_nxt = '0;
        end
      endcase
    end

    assign w_ev[g] = r_ev;
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] c);
    logic [3:0] u;
    logic [3:0] t;
    u = c[3:0];
    t = c[7:4];
    if (u >= 4'd9) begin
      u = 4'd0;
      t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] c);
    logic [3:0] u;
    logic [3:0] t;
    u = c[3:0];
    t = c[7:4];
    if (u == 4'd0) begin
      u = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  logic [7:0] r_count;
  logic       r_step;
  logic [6:0] r_hex1;
  logic [6:0] r_hex0;
  logic [7:0] w_count_nxt;
  logic       w_step_nxt;

  always_comb begin
    w_count_nxt = r_count;
    w_step_nxt  = 1'b0;
    if (w_ev[2]) begin
      w_count_nxt = '0;
      w_step_nxt  = 1'b1;
    end else if (w_ev[0] ^ w_ev[1]) begin
      w_step_nxt  = 1'b1;
      w_count_nxt = w_ev[0] ? bcd_inc(r_count) : bcd_dec(r_count);
    end
  end

  // Digits decode the next count so they update in the same cycle as count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_step  <= 1'b0;
      r_hex1  <= 7'b1000000;
      r_hex0  <= 7'b1000000;
    end else begin
      r_count <= w_count_nxt;
      r_step  <= w_step_nxt;
      r_hex1  <= seg7(w_count_nxt[7:4]);
      r_hex0  <= seg7(w_count_nxt[3:0]);
    end
  end

  assign bus.count = r_count;
  assign bus.step  = r_step;
  assign bus.HEX1  = r_hex1;
  assign bus.HEX0  = r_hex0;

endmodule
